letc_core_top: RTL and testbench

// Bring-up core for the LETC SoC. A multicycle instruction sequencer that fetches 32-bit words

---
 rtl/letc_core_top_if.sv | 67 ++++++
 rtl/letc_core_top.sv | 165 ++++++++++++++++
 tb/tb_letc_core_top.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/letc_core_top_if.sv
`default_nettype none
// axi_if: AXI4 bundle, 32-bit address/data, with master and slave views.
interface axi_if #(
  parameter int ID_W = 4
) (
  input logic clk,
  input logic rst_n
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    input  clk, rst_n,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  clk, rst_n,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface
`default_nettype wire

// File: rtl/letc_core_top.sv
`default_nettype none
// letc_core_top: multicycle fetch/retire sequencer (JAL, MRET, sequential) over AXI4 reads,
// with a two-source interrupt trap. Rev 1.0
module letc_core_top #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  axi_if.master      axi,
  input  logic       i_timer_irq_pending,
  input  logic       i_external_irq_pending,
  output logic [7:0] o_debug
);
  typedef enum logic [1:0] {
    FETCH_AR = 2'd0,
    FETCH_R  = 2'd1,
    EXEC     = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] MRET_WORD = 32'h3020_0073;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mepc_q, mepc_d;
  logic        mie_q, mie_d;
  logic [31:0] instr_q, instr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [7:0]  debug_q, debug_d;

  logic [31:0] jal_imm;
  logic [31:0] jal_target;
  logic        is_jal;
  logic        is_mret;
  logic [31:0] next_pc;
  logic        irq_take;

  always_comb begin
    jal_imm    = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
    jal_target = pc_q + jal_imm;
    is_jal     = (instr_q[6:0] == 7'b1101111);
    is_mret    = (instr_q == MRET_WORD);
    if (is_jal) begin
      next_pc = jal_target;
    end else if (is_mret) begin
      next_pc = mepc_q;
    end else begin
      next_pc = pc_q + 32'd4;
    end
    // No cause register exists yet, so external-over-timer priority collapses to a single trap.
    irq_take = mie_q && (i_external_irq_pending || i_timer_irq_pending);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mepc_d    = mepc_q;
    mie_d     = mie_q;
    instr_d   = instr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    debug_d   = debug_q;
    case (state_q)
      FETCH_AR: begin
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
        end else if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = FETCH_R;
        end
      end
      FETCH_R: begin
        if (axi.rvalid && rready_q) begin
          instr_d  = axi.rdata;
          rready_d = 1'b0;
          if (axi.rresp == RESP_OKAY) begin
            state_d = EXEC;
          end else begin
            state_d = HALT;
            debug_d = 8'hFF;
          end
        end
      end
      EXEC: begin
        debug_d = instr_q[7:0];
        if (is_jal && jal_target[1]) begin
          state_d = HALT;
          debug_d = 8'hFF;
        end else begin
          state_d   = FETCH_AR;
          arvalid_d = 1'b1;
          if (is_mret) begin
            mie_d = 1'b1;
          end
          if (irq_take) begin
            mepc_d = next_pc;
            pc_d   = TRAP_VECTOR;
            mie_d  = 1'b0;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        debug_d   = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= FETCH_AR;
      pc_q      <= RESET_PC;
      mepc_q    <= 32'h0;
      mie_q     <= 1'b1;
      instr_q   <= 32'h0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      debug_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mepc_q    <= mepc_d;
      mie_q     <= mie_d;
      instr_q   <= instr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      debug_q   <= debug_d;
    end
  end

  assign axi.arid    = '0;
  assign axi.araddr  = pc_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = '0;
  assign axi.awaddr  = 32'h0;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = 1'b0;
  assign axi.wdata   = 32'h0;
  assign axi.wstrb   = 4'h0;
  assign axi.wlast   = 1'b0;
  assign axi.wvalid  = 1'b0;
  assign axi.bready  = 1'b1;

  assign o_debug = debug_q;

  // Single-beat reads and an idle write side leave these inputs with nothing to do.
  logic unused_axi_inputs;
  assign unused_axi_inputs = ^{axi.clk, axi.rst_n, axi.rid, axi.rlast, axi.awready,
                               axi.wready, axi.bid, axi.bresp, axi.bvalid};
endmodule
`default_nettype wire

// File: tb/tb_letc_core_top.sv
`default_nettype none
// tb_letc_core_top: directed bench for letc_core_top with a behavioural AXI word-memory slave.
module tb_letc_core_top;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MRET = 32'h3020_0073;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       timer_irq = 1'b0;
  logic       ext_irq = 1'b0;
  logic [7:0] debug;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [128];
  int          ar_delay = 0;
  int          err_fetch = 999;
  int          ar_wait;
  int          fetch_n;
  int          cyc = 0;
  logic [31:0] ar_log [$];
  int          ar_cyc [$];

  always #5 clk = ~clk;

  axi_if axi (.clk(clk), .rst_n(rst_n));

  letc_core_top dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .axi                   (axi),
    .i_timer_irq_pending   (timer_irq),
    .i_external_irq_pending(ext_irq),
    .o_debug               (debug)
  );

  assign axi.arready = axi.arvalid && (ar_wait >= ar_delay);
  assign axi.rid     = '0;
  assign axi.rlast   = 1'b1;
  assign axi.awready = 1'b1;
  assign axi.wready  = 1'b1;
  assign axi.bid     = '0;
  assign axi.bresp   = 2'b00;
  assign axi.bvalid  = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      axi.rvalid <= 1'b0;
      axi.rdata  <= 32'h0;
      axi.rresp  <= 2'b00;
      ar_wait    <= 0;
      fetch_n    <= 0;
      ar_log.delete();
      ar_cyc.delete();
    end else if (axi.arvalid && axi.arready) begin
      ar_wait    <= 0;
      ar_log.push_back(axi.araddr);
      ar_cyc.push_back(cyc);
      axi.rvalid <= 1'b1;
      axi.rdata  <= mem[axi.araddr[8:2]];
      axi.rresp  <= (fetch_n == err_fetch) ? 2'b10 : 2'b00;
      fetch_n    <= fetch_n + 1;
    end else begin
      if (axi.arvalid) ar_wait <= ar_wait + 1;
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 128; i++) mem[i] = NOP;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_fetches(input int n, input string tag);
    int k = 0;
    while (ar_log.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (ar_log.size() < n) check(tag, ar_log.size(), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable;

    // 1: reset state, then straight-line NOP fetch with a zero-wait slave
    fill_nop();
    hold_reset();
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_rready", axi.rready, 0);
    check("rst_debug", debug, 8'h00);
    check("rst_araddr", axi.araddr, 32'h0);
    check("awvalid_idle", axi.awvalid, 0);
    check("wvalid_idle", axi.wvalid, 0);
    check("bready_high", axi.bready, 1);
    check("ar_fields", {axi.arlen, 1'b0, axi.arsize, 2'b00, axi.arburst}, {8'd0, 1'b0, 3'b010, 2'b00, 2'b01});
    rst_n = 1'b1;
    @(negedge clk);
    check("first_arvalid", axi.arvalid, 1);
    wait_fetches(4, "t1_fetch_timeout");
    check("t1_addr0", ar_log[0], 32'h0);
    check("t1_addr1", ar_log[1], 32'h4);
    check("t1_addr2", ar_log[2], 32'h8);
    check("t1_addr3", ar_log[3], 32'hC);
    check("t1_period01", ar_cyc[1] - ar_cyc[0], 3);
    check("t1_period23", ar_cyc[3] - ar_cyc[2], 3);
    check("t1_debug", debug, 8'h13);

    // 2: arready withheld for 5 cycles
    ar_delay = 5;
    hold_reset();
    rst_n = 1'b1;
    @(negedge clk);
    stable = 1'b1;
    repeat (5) begin
      if (!(axi.arvalid === 1'b1 && axi.araddr === 32'h0 && ar_log.size() == 0)) stable = 1'b0;
      @(negedge clk);
    end
    check("t2_ar_held", stable, 1);
    wait_fetches(1, "t2_fetch_timeout");
    @(negedge clk);
    check("t2_single_hs", ar_log.size(), 1);
    check("t2_addr0", ar_log[0], 32'h0);
    ar_delay = 0;

    // 3: JAL +16 then JAL -4
    fill_nop();
    mem[0] = 32'h0100_006F;
    mem[4] = 32'hFFDF_F06F;
    hold_reset();
    rst_n = 1'b1;
    wait_fetches(4, "t3_fetch_timeout");
    check("t3_jal_fwd", ar_log[1], 32'h10);
    check("t3_jal_back", ar_log[2], 32'hC);
    check("t3_seq_after", ar_log[3], 32'h10);

    // 4: timer held high from reset, MRET at the trap vector
    fill_nop();
    mem[64] = MRET;
    timer_irq = 1'b1;
    hold_reset();
    rst_n = 1'b1;
    wait_fetches(5, "t4_fetch_timeout");
    check("t4_trap", ar_log[1], 32'h100);
    check("t4_mret_mepc", ar_log[2], 32'h4);
    check("t4_retrap", ar_log[3], 32'h100);
    check("t4_mret2", ar_log[4], 32'h8);
    timer_irq = 1'b0;

    // 5: both sources pending in one EXEC, dropped before MRET retires
    ext_irq = 1'b1;
    timer_irq = 1'b1;
    hold_reset();
    rst_n = 1'b1;
    wait_fetches(2, "t5_trap_timeout");
    ext_irq = 1'b0;
    timer_irq = 1'b0;
    wait_fetches(4, "t5_fetch_timeout");
    check("t5_trap", ar_log[1], 32'h100);
    check("t5_resume", ar_log[2], 32'h4);
    check("t5_no_retrap", ar_log[3], 32'h8);

    // 6: SLVERR on the third fetch, then a one-cycle reset pulse
    fill_nop();
    err_fetch = 2;
    hold_reset();
    rst_n = 1'b1;
    wait_fetches(3, "t6_fetch_timeout");
    repeat (3) @(negedge clk);
    stable = 1'b1;
    repeat (8) begin
      if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    check("t6_halt_quiet", stable, 1);
    check("t6_halt_debug", debug, 8'hFF);
    check("t6_no_refetch", ar_log.size(), 3);
    err_fetch = 999;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_pulse_debug", debug, 8'h00);
    check("t6_pulse_arvalid", axi.arvalid, 0);
    wait_fetches(2, "t6_refetch_timeout");
    check("t6_refetch0", ar_log[0], 32'h0);
    check("t6_refetch1", ar_log[1], 32'h4);

    // 7: JAL to a half-word aligned target halts
    mem[0] = 32'h0020_006F;
    hold_reset();
    rst_n = 1'b1;
    wait_fetches(1, "t7_fetch_timeout");
    repeat (10) @(negedge clk);
    check("t7_halt_debug", debug, 8'hFF);
    check("t7_no_fetch", ar_log.size(), 1);
    check("t7_arvalid", axi.arvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
